// File: rtl/priority_encoder_8x3_seq.sv
// Sequential priority encoder: captures a request vector and emits the index of
// each set bit, highest first, one beat per accepted output handshake.
module priority_encoder_8x3_seq #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_none,
  output logic               out_last,
  output logic [IDX_W:0]     out_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   pending, pending_n;
  logic               out_valid_n, out_none_n, out_last_n;
  logic [IDX_W-1:0]   out_idx_n;
  logic [IDX_W:0]     out_count_n;
  logic [WIDTH-1:0]   remaining;

  function automatic logic [IDX_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) msb_idx = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++)
      popcount = popcount + {{IDX_W{1'b0}}, v[i]};
  endfunction

  // True for zero or one set bit; a zero vector is also a single (last) beat.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    at_most_one = ((v & (v - 1'b1)) == '0);
  endfunction

  assign in_ready  = (state == IDLE) && enable && rst_n;
  assign remaining = pending & ~(WIDTH'(1) << out_idx);

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_none_n  = out_none;
    out_last_n  = out_last;
    out_count_n = out_count;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n     = EMIT;
          pending_n   = in_vec;
          out_valid_n = 1'b1;
          out_idx_n   = msb_idx(in_vec);
          out_none_n  = (in_vec == '0);
          out_last_n  = at_most_one(in_vec);
          out_count_n = popcount(in_vec);
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          pending_n = remaining;
          if (out_last) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
          end else begin
            out_idx_n  = msb_idx(remaining);
            out_last_n = at_most_one(remaining);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_none  <= out_none_n;
      out_last  <= out_last_n;
      out_count <= out_count_n;
    end
  end

endmodule

// File: tb/tb_priority_encoder_8x3_seq.sv
// Directed bench for priority_encoder_8x3_seq: inputs driven and outputs checked
// on the falling edge, expected values written by hand.
module tb_priority_encoder_8x3_seq;

  logic       clk = 1'b0;
  logic       rst_n, enable, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_vec;
  logic [2:0] out_idx;
  logic       out_none, out_last;
  logic [3:0] out_count;

  int n_total = 0;
  int n_pass  = 0;

  priority_encoder_8x3_seq #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_none(out_none), .out_last(out_last),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_beat(input string tag, input int idx, input bit last,
                          input int cnt, input bit none);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".count"}, 32'(out_count), 32'(cnt));
    chk({tag, ".none"},  32'(out_none),  32'(none));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idx"},   32'(out_idx),   32'd0);
    chk({tag, ".none"},  32'(out_none),  32'd0);
    chk({tag, ".last"},  32'(out_last),  32'd0);
    chk({tag, ".count"}, 32'(out_count), 32'd0);
  endtask

  task automatic send(input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    chk("send.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = 8'h00;
    @(negedge clk);
    tick();
    chk_reset_vals("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    // single set bit
    out_ready = 1'b1;
    send(8'b0010_0000);
    chk_beat("one_hot", 5, 1, 1, 0);
    chk("one_hot.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("one_hot.done", 32'(out_valid), 32'd0);
    chk("one_hot.in_ready_back", 32'(in_ready), 32'd1);

    // three bits, continuous ready
    send(8'b1000_0101);
    chk_beat("v85.b0", 7, 0, 3, 0); tick();
    chk_beat("v85.b1", 2, 0, 3, 0); tick();
    chk_beat("v85.b2", 0, 1, 3, 0); tick();
    chk("v85.done", 32'(out_valid), 32'd0);

    // all bits with backpressure; enable dropped then raised mid-emission
    send(8'hFF);
    enable = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) enable = 1'b1;
      out_ready = 1'b1;
      chk_beat($sformatf("ff.b%0d", i), i, (i == 0), 8, 0);
      chk($sformatf("ff.in_ready%0d", i), 32'(in_ready), 32'd0);
      if (i != 7) begin
        out_ready = 1'b0;
        tick();
        chk_beat($sformatf("ff.hold%0d_a", i), i, (i == 0), 8, 0);
        tick();
        chk_beat($sformatf("ff.hold%0d_b", i), i, (i == 0), 8, 0);
        out_ready = 1'b1;
      end
      tick();
    end
    chk("ff.done", 32'(out_valid), 32'd0);
    chk("ff.in_ready_back", 32'(in_ready), 32'd1);

    // zero vector
    send(8'h00);
    chk_beat("zero", 0, 1, 0, 1);
    tick();
    chk("zero.done", 32'(out_valid), 32'd0);

    // reset mid-emission, coinciding with the second beat's handshake
    send(8'b1100_0011);
    chk_beat("c3.b0", 7, 0, 4, 0); tick();
    chk_beat("c3.b1", 6, 0, 4, 0);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("c3.reset");
    rst_n = 1'b1;
    tick();
    chk("c3.no_more", 32'(out_valid), 32'd0);
    chk("c3.in_ready", 32'(in_ready), 32'd1);

    // reset in the same cycle as an input handshake attempt
    in_vec = 8'h10; in_valid = 1'b1; rst_n = 1'b0;
    #1 chk("rst_hs.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_reset_vals("rst_hs");
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("rst_hs.no_beat", 32'(out_valid), 32'd0);

    // enable low blocks capture
    enable = 1'b0; in_vec = 8'h04; in_valid = 1'b1;
    #1 chk("en0.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("en0.no_beat_a", 32'(out_valid), 32'd0);
    tick();
    chk("en0.no_beat_b", 32'(out_valid), 32'd0);
    enable = 1'b1;
    #1 chk("en1.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_beat("en1", 2, 1, 1, 0);
    tick();
    chk("en1.done", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/priority_encoder_8x3_seq.md
Name: priority_encoder_8x3_seq

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3x8 / 2x4 decoder blocks.
- Accepts a one-or-more-hot request vector over a valid/ready handshake.
- Emits the 3-bit index of each set bit, one per beat, highest index first, over a second valid/ready handshake.
- Sits between decoded select lines (interrupt, chip-select or grant vectors) and logic that needs binary indices.

Parameters:
- WIDTH, 8, request vector width; must be a power of two and at least 2.
- IDX_W, 3, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- enable  input  1  gates acceptance of new vectors only; does not stall emission.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  request vector; bit i set means index i is to be encoded.
- out_valid  output  1  out_idx, out_none, out_last and out_count are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_idx  output  IDX_W  encoded index of the highest remaining set bit.
- out_none  output  1  captured vector was all zeros; out_idx is 0 on this beat.
- out_last  output  1  final beat for the captured vector.
- out_count  output  IDX_W+1  popcount of the captured vector; held for every beat of that vector.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state to IDLE; pending register to 0.
  - out_valid, out_idx, out_none, out_last and out_count to 0.
  - Reset overrides any handshake in the same cycle, including mid-emission; no further beats of the aborted vector are emitted.
- States: IDLE, EMIT.
- in_ready:
  - Combinational: in_ready = (state == IDLE) && enable && rst_n.
  - Never asserted in EMIT; there is no overlap between vectors.
- IDLE:
  - On in_valid && in_ready, capture in_vec into pending and popcount(in_vec) into out_count.
  - Go to EMIT and assert out_valid from the next cycle. Latency is one cycle from the input handshake to the first out_valid.
- First beat:
  - out_idx = index of the highest set bit of pending.
  - out_last = 1 when pending has exactly one set bit.
  - out_none = 0.
- Zero vector:
  - A single beat with out_none = 1, out_idx = 0, out_last = 1 and out_count = 0.
- EMIT, on out_valid && out_ready:
  - Clear the bit just emitted from pending.
  - If out_last was 1, go to IDLE with out_valid = 0 in the next cycle.
  - Otherwise present the next-highest set bit in the next cycle, with out_last recomputed. This gives one beat per cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, out_idx, out_none, out_last and out_count hold stable, and out_valid must not drop.
- enable low during EMIT has no effect on emission; only the next capture is blocked.
- out_idx, out_last, out_none, out_valid and out_count are registered outputs; there is no combinational path from out_ready to the outputs.
- The return to IDLE costs one cycle, so back-to-back vectors have a minimum spacing of popcount + 1 cycles (zero vector: 2 cycles).
- Width: out_count is IDX_W+1 bits so that WIDTH set bits (8) is representable.

Test Plan:
- Reset, then in_vec = 8'b0010_0000 with out_ready = 1 → one beat next cycle: out_idx = 5, out_last = 1, out_count = 1; in_ready returns to 1 one cycle later.
- in_vec = 8'b1000_0101 with out_ready = 1 → three consecutive beats, out_idx 7, 2, 0; out_last only on index 0; out_count = 3 on all beats.
- in_vec = 8'hFF with out_ready toggling 1,0,0,1,... → indices 7 down to 0, each held stable while out_ready = 0; out_count = 8; in_ready = 0 throughout.
- in_vec = 8'h00 → single beat: out_none = 1, out_idx = 0, out_last = 1, out_count = 0.
- Each of the following → no further beats, with all reset values listed in Behaviour:
  - rst_n low for one edge after the second beat of 8'b1100_0011;
  - rst_n low in the same cycle as an input handshake.
- enable = 0 with in_valid = 1 → in_ready = 0, no capture. Raise enable during an active EMIT → in_ready stays 0 until the final beat completes.
